// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with byte FIFO and status register
module mmio_uart_tx #(
  parameter int          CLK_DIV     = 16,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] TX_ADDR     = 32'h0000_1000,
  parameter logic [31:0] STATUS_ADDR = 32'h0000_1004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  write_byte_en,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [31:0] raddr,
  output logic [31:0] rdata,
  output logic        rsel,
  output logic        txd,
  output logic        busy
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic store, push_req, clr_req, fifo_empty, fifo_full, baud_end, pop, push_ok, ovf_set;
  logic unused_wdata_hi;

  // Only the low byte of a data store is transmitted.
  assign unused_wdata_hi = ^wdata[31:8];

  assign store      = |write_byte_en;
  assign push_req   = store && (waddr == TX_ADDR);
  assign clr_req    = store && (waddr == STATUS_ADDR) && wdata[2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign baud_end   = (baud_q == BAUD_MAX);

  assign busy  = (state_q != IDLE) || !fifo_empty;
  assign rsel  = (raddr == STATUS_ADDR);
  assign rdata = rsel ? {29'b0, ovf_q, fifo_full, busy} : 32'h0;
  assign txd   = txd_q;

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves the same cycle.
  always_comb begin
    push_ok  = push_req && (!fifo_full || pop);
    ovf_set  = push_req && fifo_full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A fresh overflow wins over a clear in the same cycle.
    ovf_d = ovf_set | (ovf_q & ~clr_req);
  end

  // State registers; reset drops any frame in flight and idles the line high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a queue-based frame model
module tb_mmio_uart_tx;

  localparam int          CD     = 4;
  localparam int          DEPTH  = 4;
  localparam int          FRAME  = 10 * CD;
  localparam logic [31:0] TX_A   = 32'h0000_1000;
  localparam logic [31:0] STAT_A = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  write_byte_en = '0;
  logic [31:0] waddr = '0, wdata = '0, raddr = STAT_A;
  logic [31:0] rdata;
  logic        rsel, txd, busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending bytes, current frame as a 10-bit pattern and its cycle index.
  logic [7:0] m_q[$];
  bit         m_in_frame = 0;
  int         m_t = 0;
  logic [9:0] m_bits = '1;
  bit         m_ovf = 0;

  mmio_uart_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .TX_ADDR(TX_A), .STATUS_ADDR(STAT_A)) dut (
    .clk(clk), .rst(rst), .write_byte_en(write_byte_en), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rsel(rsel), .txd(txd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_frame = 0;
    m_t = 0;
    m_bits = '1;
    m_ovf = 0;
  endtask

  task automatic model_step(input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
    bit push, clr, frame_end, pop, full, accept;
    logic [7:0] b;
    push      = (we != 0) && (a == TX_A);
    clr       = (we != 0) && (a == STAT_A) && d[2];
    frame_end = m_in_frame && (m_t == FRAME - 1);
    pop       = (m_q.size() > 0) && (!m_in_frame || frame_end);
    full      = (m_q.size() == DEPTH);
    accept    = 0;
    if (clr) m_ovf = 0;
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else accept = 1;
    end
    if (pop) begin
      b = m_q.pop_front();
      m_bits = {1'b1, b, 1'b0};
      m_t = 0;
      m_in_frame = 1;
    end else if (frame_end) begin
      m_in_frame = 0;
    end else if (m_in_frame) begin
      m_t++;
    end
    if (accept) m_q.push_back(d[7:0]);
  endtask

  function automatic logic exp_txd();
    return m_in_frame ? m_bits[m_t / CD] : 1'b1;
  endfunction

  function automatic logic exp_busy();
    return m_in_frame || (m_q.size() > 0);
  endfunction

  function automatic logic [31:0] exp_status();
    return {29'b0, m_ovf, (m_q.size() == DEPTH), exp_busy()};
  endfunction

  task automatic check_outputs();
    chk("txd", {31'b0, txd}, {31'b0, exp_txd()});
    chk("busy", {31'b0, busy}, {31'b0, exp_busy()});
    chk("rsel", {31'b0, rsel}, 32'h1);
    chk("status", rdata, exp_status());
  endtask

  task automatic tick(input logic [1:0] we, input logic [31:0] a, input logic [31:0] d);
    write_byte_en = we;
    waddr = a;
    wdata = d;
    @(posedge clk);
    model_step(we, a, d);
    #1;
    write_byte_en = '0;
    waddr = '0;
    wdata = '0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(2'b00, 32'h0, 32'h0);
  endtask

  task automatic push(input logic [7:0] b);
    tick(2'($urandom_range(1, 3)), TX_A, {24'($urandom), b});
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_status", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single byte 0x55, the first push right after reset release.
    push(8'h55);
    idle(45);

    // Back-to-back frames.
    push(8'hA5);
    push(8'h3C);
    idle(85);

    // Overflow: six pushes from idle, sixth dropped, then clear.
    for (int i = 0; i < 6; i++) push(8'($urandom));
    chk("ovf_status", rdata, 32'h7);
    tick(2'b01, STAT_A, 32'h4);
    chk("clr_status", rdata, 32'h3);
    idle(5 * FRAME + 5);

    // Push on the edge the stop bit ends while full.
    for (int i = 0; i < 5; i++) push(8'($urandom));
    for (int i = 0; i < 100 && !(m_in_frame && m_t == FRAME - 1); i++) idle(1);
    chk("coinc_reach", {31'b0, (m_in_frame && m_t == FRAME - 1)}, 32'h1);
    chk("coinc_full", {31'b0, rdata[1]}, 32'h1);
    push(8'h99);
    chk("coinc_ovf", {31'b0, rdata[2]}, 32'h0);
    chk("coinc_full2", {31'b0, rdata[1]}, 32'h1);
    idle(5 * FRAME + 5);

    // Address decode: stray store and load from the data address.
    tick(2'b11, TX_A + 32'h8, 32'h0000_00AB);
    chk("stray_busy", {31'b0, busy}, 32'h0);
    raddr = TX_A;
    #1;
    chk("ld_tx_rsel", {31'b0, rsel}, 32'h0);
    chk("ld_tx_rdata", rdata, 32'h0);
    raddr = STAT_A;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) push(8'($urandom));
      else if (r == 3) tick(2'($urandom_range(1, 3)), STAT_A, $urandom);
      else if (r == 4) tick(2'b01, TX_A + 32'h8 + 32'(4 * $urandom_range(0, 6)), $urandom);
      else idle(1);
    end
    for (int i = 0; i < 400 && exp_busy(); i++) idle(1);
    chk("drain", {31'b0, busy}, 32'h0);
    tick(2'b01, STAT_A, 32'h4);

    // Reset in the middle of data bit 3.
    push(8'($urandom));
    for (int i = 0; i < 100 && !(m_in_frame && (m_t / CD) == 4); i++) idle(1);
    chk("midrst_reach", {31'b0, (m_in_frame && (m_t / CD) == 4)}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_txd", {31'b0, txd}, 32'h1);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_status", rdata, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("midrst_hold_txd", {31'b0, txd}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    push(8'h01);
    idle(45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLK_DIV, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, at least 2.
REQ-003 Parameter TX_ADDR, default 32'h0000_1000, byte address of the transmit data register.
REQ-004 Parameter STATUS_ADDR, default 32'h0000_1004, byte address of the status/control register.
REQ-005 clk  input  1  rising-edge clock shared with sr_cpu and data_ram.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 write_byte_en  input  2  CPU store strobe; any nonzero value means a store this cycle.
REQ-008 waddr  input  32  CPU store address.
REQ-009 wdata  input  32  CPU store data.
REQ-010 raddr  input  32  CPU load address.
REQ-011 rdata  output  32  status word when raddr == STATUS_ADDR, else 0; combinational.
REQ-012 rsel  output  1  high when raddr == STATUS_ADDR; combinational; the system mux uses it to select rdata over data_ram.
REQ-013 txd  output  1  serial line; registered; idle high.
REQ-014 busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Function
REQ-015 Push: on a rising edge with write_byte_en != 0 and waddr == TX_ADDR, the block SHALL enqueue wdata[7:0]; wdata[31:8] SHALL be ignored.
REQ-016 Overflow: a push while the FIFO is full and no pop occurs in the same cycle SHALL drop the byte and set the sticky overflow flag.
REQ-017 Push and pop in the same cycle with the FIFO full SHALL both succeed, with no overflow.
REQ-018 Clear: on an edge with write_byte_en != 0, waddr == STATUS_ADDR and wdata[2] == 1, overflow SHALL clear; the write SHALL have no other effect.
REQ-019 If clear and a new overflow occur in the same cycle, overflow SHALL end the cycle set.
REQ-020 Status word: bit0 = busy, bit1 = fifo_full, bit2 = overflow, bits 31:3 = 0.
REQ-021 Reads SHALL have no side effects.
REQ-022 FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..CLK_DIV-1) run alongside the FSM.
REQ-023 IDLE: txd = 1. On the first edge where the FIFO is non-empty, the block SHALL pop the head byte into the shift register, drive txd to 0, and enter START.
REQ-024 A byte pushed at edge N SHALL produce txd = 0 from edge N+1; there is no same-edge bypass.
REQ-025 Each START, DATA and STOP bit SHALL hold txd for exactly CLK_DIV cycles.
REQ-026 DATA SHALL send 8 bits LSB first, then enter STOP with txd = 1.
REQ-027 At the end of STOP, the block SHALL pop and go directly to START if the FIFO is non-empty, otherwise go to IDLE.
REQ-028 A frame SHALL be exactly 10*CLK_DIV cycles; back-to-back frames SHALL have no idle gap.
REQ-029 busy SHALL be (state != IDLE) or (FIFO non-empty).
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with count kept in log2(FIFO_DEPTH)+1 bits.
REQ-031 Stores to any other address SHALL be ignored.

Reset
REQ-032 While rst == 0, asynchronously: txd = 1, state = IDLE, FIFO empty, overflow = 0, all counters = 0, busy = 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with txd = 1 and no partial byte retained.
REQ-034 After rst deasserts, the first push SHALL be accepted on the next rising edge.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-035 Single byte: store 0x55 to TX_ADDR at edge N -> txd 0 for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 at 4 cycles each, stop 1; busy falls at edge N+41.
REQ-036 Back-to-back: push 0xA5 then 0x3C on consecutive edges -> two frames totalling 80 cycles; the start bit of the second frame immediately follows the stop bit of the first.
REQ-037 Overflow: push 6 bytes on consecutive edges from idle -> 5 accepted (one is popped after the first push), sixth dropped; status reads 32'h7. Store 32'h4 to STATUS_ADDR -> status reads 32'h3, then bytes 1-5 are transmitted in order.
REQ-038 Full push/pop coincidence: with the FIFO full, push on the same edge a stop bit ends -> byte accepted, overflow stays 0.
REQ-039 Reset mid-frame: assert rst during DATA bit 3 -> txd = 1 within the same cycle, busy = 0, FIFO empty; after release, a new byte 0x01 frames correctly.
REQ-040 Address decode: store to TX_ADDR+8 or a load from TX_ADDR -> no push; rsel = 0, rdata = 0.
